// File: rtl/wb_router.sv
// Result router: steers accepted ALU beats to the scalar RF, the vector RF
// (with per-op element sequencing) or the LSU, which has a one-deep skid register.
module wb_router #(
  parameter int XLEN  = 32,
  parameter int VLMAX = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stg_en,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] res,
  input  logic [1:0]      dest_sel,
  input  logic [4:0]      rd,
  input  logic [3:0]      vl,
  output logic            rf_we,
  output logic [4:0]      rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic            vrf_we,
  output logic [4:0]      vrf_waddr,
  output logic [2:0]      vrf_elem,
  output logic [XLEN-1:0] vrf_wdata,
  output logic            vec_done,
  output logic            lsu_valid,
  input  logic            lsu_ready,
  output logic [XLEN-1:0] lsu_data
);

  localparam logic [3:0] VLMAX_L = 4'(VLMAX);

  typedef enum logic [1:0] {IDLE, VEC, LSU_WAIT} state_e;

  // The vector sequencer and the LSU slot each hold their own state so a
  // vector op can keep running while an LSU beat is stalled.
  state_e vec_state_q, vec_state_d;
  state_e lsu_state_q, lsu_state_d;

  logic [2:0]      elem_cnt_q, elem_cnt_d;
  logic            rf_we_q, rf_we_d;
  logic [4:0]      rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;
  logic            vrf_we_q, vrf_we_d;
  logic [4:0]      vrf_waddr_q, vrf_waddr_d;
  logic [2:0]      vrf_elem_q, vrf_elem_d;
  logic [XLEN-1:0] vrf_wdata_q, vrf_wdata_d;
  logic            vec_done_q, vec_done_d;
  logic [XLEN-1:0] lsu_data_q, lsu_data_d;

  logic       lsu_pending;
  logic       accept;
  logic [3:0] vl_eff;
  logic [2:0] cur_elem;
  logic [2:0] next_elem;
  logic       last_elem;

  assign lsu_pending = (lsu_state_q == LSU_WAIT);
  assign in_ready    = !rst && stg_en && (!lsu_pending || lsu_ready);
  assign accept      = in_valid && in_ready;
  assign vl_eff      = (vl > VLMAX_L) ? VLMAX_L : vl;
  assign cur_elem    = (vec_state_q == VEC) ? elem_cnt_q : 3'd0;
  assign next_elem   = cur_elem + 3'd1;
  assign last_elem   = ({1'b0, cur_elem} == (vl_eff - 4'd1));

  always_comb begin
    rf_we_d     = 1'b0;
    vrf_we_d    = 1'b0;
    vec_done_d  = 1'b0;
    rf_waddr_d  = rf_waddr_q;
    rf_wdata_d  = rf_wdata_q;
    vrf_waddr_d = vrf_waddr_q;
    vrf_elem_d  = vrf_elem_q;
    vrf_wdata_d = vrf_wdata_q;
    lsu_data_d  = lsu_data_q;
    elem_cnt_d  = elem_cnt_q;
    vec_state_d = vec_state_q;
    lsu_state_d = lsu_state_q;

    if (lsu_pending && lsu_ready) begin
      lsu_state_d = IDLE;
    end

    if (accept) begin
      unique case (dest_sel)
        2'b00: begin
          if (rd != 5'd0) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = rd;
            rf_wdata_d = res;
          end
        end
        2'b01: begin
          if (vl_eff != 4'd0) begin
            vrf_we_d    = 1'b1;
            vrf_waddr_d = rd;
            vrf_elem_d  = cur_elem;
            vrf_wdata_d = res;
            if (last_elem) begin
              vec_done_d  = 1'b1;
              elem_cnt_d  = 3'd0;
              vec_state_d = IDLE;
            end else begin
              elem_cnt_d  = next_elem;
              vec_state_d = (next_elem == 3'd0) ? IDLE : VEC;
            end
          end
        end
        2'b10: begin
          // A new beat may load in the same cycle the old one hands off.
          lsu_state_d = LSU_WAIT;
          lsu_data_d  = res;
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vec_state_q <= IDLE;
      lsu_state_q <= IDLE;
      elem_cnt_q  <= '0;
      rf_we_q     <= 1'b0;
      rf_waddr_q  <= '0;
      rf_wdata_q  <= '0;
      vrf_we_q    <= 1'b0;
      vrf_waddr_q <= '0;
      vrf_elem_q  <= '0;
      vrf_wdata_q <= '0;
      vec_done_q  <= 1'b0;
      lsu_data_q  <= '0;
    end else begin
      vec_state_q <= vec_state_d;
      lsu_state_q <= lsu_state_d;
      elem_cnt_q  <= elem_cnt_d;
      rf_we_q     <= rf_we_d;
      rf_waddr_q  <= rf_waddr_d;
      rf_wdata_q  <= rf_wdata_d;
      vrf_we_q    <= vrf_we_d;
      vrf_waddr_q <= vrf_waddr_d;
      vrf_elem_q  <= vrf_elem_d;
      vrf_wdata_q <= vrf_wdata_d;
      vec_done_q  <= vec_done_d;
      lsu_data_q  <= lsu_data_d;
    end
  end

  assign rf_we     = rf_we_q;
  assign rf_waddr  = rf_waddr_q;
  assign rf_wdata  = rf_wdata_q;
  assign vrf_we    = vrf_we_q;
  assign vrf_waddr = vrf_waddr_q;
  assign vrf_elem  = vrf_elem_q;
  assign vrf_wdata = vrf_wdata_q;
  assign vec_done  = vec_done_q;
  assign lsu_valid = lsu_pending;
  assign lsu_data  = lsu_data_q;

endmodule

// File: tb/tb_wb_router.sv
// Directed plus randomized bench for wb_router, scored against a
// transaction-level model of routing, vector sequencing and the LSU slot.
module tb_wb_router;

  logic        clk = 1'b0;
  logic        rst, stg_en, in_valid, in_ready;
  logic [31:0] res;
  logic [1:0]  dest_sel;
  logic [4:0]  rd;
  logic [3:0]  vl;
  logic        rf_we, vrf_we, vec_done, lsu_valid, lsu_ready;
  logic [4:0]  rf_waddr, vrf_waddr;
  logic [2:0]  vrf_elem;
  logic [31:0] rf_wdata, vrf_wdata, lsu_data;

  int checks = 0;
  int errors = 0;

  // Model of what the router should be presenting after the next edge.
  logic        e_rf_we, e_vrf_we, e_done;
  logic [4:0]  e_rf_waddr, e_vrf_waddr;
  logic [2:0]  e_vrf_elem;
  logic [31:0] e_rf_wdata, e_vrf_wdata;
  int          m_elem;
  logic        m_lsu_pend;
  logic [31:0] m_lsu_data;
  logic [3:0]  cur_vl;

  wb_router #(.XLEN(32), .VLMAX(8)) dut (
    .clk(clk), .rst(rst), .stg_en(stg_en), .in_valid(in_valid), .in_ready(in_ready),
    .res(res), .dest_sel(dest_sel), .rd(rd), .vl(vl),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .vrf_we(vrf_we), .vrf_waddr(vrf_waddr), .vrf_elem(vrf_elem), .vrf_wdata(vrf_wdata),
    .vec_done(vec_done), .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_data(lsu_data)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic s, input logic v, input logic [1:0] sel,
                               input logic [4:0] d, input logic [3:0] l, input logic [31:0] data,
                               input logic lr);
    rst = r; stg_en = s; in_valid = v; dest_sel = sel; rd = d; vl = l; res = data; lsu_ready = lr;
    #1;
  endtask

  task automatic stepCycle();
    logic exp_ready;
    int   n;
    exp_ready = !rst && stg_en && (!m_lsu_pend || lsu_ready);
    checkOutput("in_ready", 32'(in_ready), 32'(exp_ready));
    if (rst) begin
      e_rf_we = 0; e_vrf_we = 0; e_done = 0;
      e_rf_waddr = 0; e_rf_wdata = 0; e_vrf_waddr = 0; e_vrf_elem = 0; e_vrf_wdata = 0;
      m_elem = 0; m_lsu_pend = 0; m_lsu_data = 0;
    end else begin
      e_rf_we = 0; e_vrf_we = 0; e_done = 0;
      if (m_lsu_pend && lsu_ready) m_lsu_pend = 0;
      if (in_valid && exp_ready) begin
        case (dest_sel)
          2'd0: if (rd != 0) begin
            e_rf_we = 1; e_rf_waddr = rd; e_rf_wdata = res;
          end
          2'd1: begin
            n = (vl > 8) ? 8 : int'(vl);
            if (n > 0) begin
              e_vrf_we = 1; e_vrf_waddr = rd; e_vrf_elem = 3'(m_elem); e_vrf_wdata = res;
              if (m_elem == n - 1) begin
                e_done = 1; m_elem = 0;
              end else begin
                m_elem = (m_elem + 1) % 8;
              end
            end
          end
          2'd2: begin
            m_lsu_pend = 1; m_lsu_data = res;
          end
          default: ;
        endcase
      end
    end
    @(posedge clk);
    #1;
    checkOutput("rf_we", 32'(rf_we), 32'(e_rf_we));
    checkOutput("rf_waddr", 32'(rf_waddr), 32'(e_rf_waddr));
    checkOutput("rf_wdata", rf_wdata, e_rf_wdata);
    checkOutput("vrf_we", 32'(vrf_we), 32'(e_vrf_we));
    checkOutput("vrf_waddr", 32'(vrf_waddr), 32'(e_vrf_waddr));
    checkOutput("vrf_elem", 32'(vrf_elem), 32'(e_vrf_elem));
    checkOutput("vrf_wdata", vrf_wdata, e_vrf_wdata);
    checkOutput("vec_done", 32'(vec_done), 32'(e_done));
    checkOutput("lsu_valid", 32'(lsu_valid), 32'(m_lsu_pend));
    checkOutput("lsu_data", lsu_data, m_lsu_data);
  endtask

  initial begin
    m_elem = 0; m_lsu_pend = 0; m_lsu_data = 0; cur_vl = 0;
    e_rf_we = 0; e_vrf_we = 0; e_done = 0;
    e_rf_waddr = 0; e_rf_wdata = 0; e_vrf_waddr = 0; e_vrf_elem = 0; e_vrf_wdata = 0;

    // Reset with a live beat offered: nothing may be accepted.
    applyStimulus(1, 1, 1, 2'd2, 5'd3, 4'd3, 32'h55, 1);
    checkOutput("reset_in_ready", 32'(in_ready), 32'd0);
    stepCycle();
    applyStimulus(1, 1, 0, 2'd0, 5'd0, 4'd0, 32'h0, 0);
    stepCycle();

    // Scalar path and write pulse length.
    applyStimulus(0, 1, 1, 2'd0, 5'd5, 4'd0, 32'hDEADBEEF, 0);
    stepCycle();
    checkOutput("scalar_we", 32'(rf_we), 32'd1);
    checkOutput("scalar_waddr", 32'(rf_waddr), 32'd5);
    checkOutput("scalar_wdata", rf_wdata, 32'hDEADBEEF);
    applyStimulus(0, 1, 0, 2'd0, 5'd0, 4'd0, 32'h0, 0);
    stepCycle();
    checkOutput("scalar_we_drop", 32'(rf_we), 32'd0);

    // Write to x0 is suppressed.
    applyStimulus(0, 1, 1, 2'd0, 5'd0, 4'd0, 32'h1234, 0);
    stepCycle();
    checkOutput("x0_we", 32'(rf_we), 32'd0);

    // Vector sweep vl=3 then wrap to element 0.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(0, 1, 1, 2'd1, 5'd2, 4'd3, 32'h10 + 32'(i), 0);
      stepCycle();
      checkOutput("vec_elem", 32'(vrf_elem), 32'(i % 3));
      checkOutput("vec_done_pulse", 32'(vec_done), 32'(i % 3 == 2));
    end

    // LSU backpressure, then back-to-back LSU beat, then scalar beside handshake.
    applyStimulus(0, 1, 1, 2'd2, 5'd0, 4'd0, 32'h1000, 0);
    stepCycle();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, 1, 2'd2, 5'd0, 4'd0, 32'hBAD, 0);
      checkOutput("lsu_stall_ready", 32'(in_ready), 32'd0);
      stepCycle();
      checkOutput("lsu_hold_data", lsu_data, 32'h1000);
      checkOutput("lsu_hold_valid", 32'(lsu_valid), 32'd1);
    end
    applyStimulus(0, 1, 1, 2'd2, 5'd0, 4'd0, 32'h2000, 1);
    checkOutput("lsu_release_ready", 32'(in_ready), 32'd1);
    stepCycle();
    checkOutput("lsu_b2b_valid", 32'(lsu_valid), 32'd1);
    checkOutput("lsu_b2b_data", lsu_data, 32'h2000);
    applyStimulus(0, 1, 1, 2'd0, 5'd9, 4'd0, 32'hCAFE, 1);
    stepCycle();
    checkOutput("combo_rf_we", 32'(rf_we), 32'd1);
    checkOutput("combo_lsu_valid", 32'(lsu_valid), 32'd0);

    // Reset mid vector op with an LSU beat pending.
    applyStimulus(0, 1, 1, 2'd1, 5'd4, 4'd4, 32'hA0, 0); stepCycle();
    applyStimulus(0, 1, 1, 2'd1, 5'd4, 4'd4, 32'hA1, 0); stepCycle();
    applyStimulus(0, 1, 1, 2'd2, 5'd0, 4'd4, 32'h3000, 0); stepCycle();
    applyStimulus(1, 1, 1, 2'd1, 5'd4, 4'd4, 32'hA2, 1); stepCycle();
    checkOutput("rst_lsu_valid", 32'(lsu_valid), 32'd0);
    checkOutput("rst_lsu_data", lsu_data, 32'd0);
    checkOutput("rst_vrf_we", 32'(vrf_we), 32'd0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 1, 1, 2'd1, 5'd4, 4'd4, 32'hB0 + 32'(i), 0);
      stepCycle();
      checkOutput("post_rst_elem", 32'(vrf_elem), 32'(i));
    end

    // Stage disable with a pending LSU beat, then vl=0 and vl>VLMAX beats.
    applyStimulus(0, 1, 1, 2'd2, 5'd0, 4'd0, 32'h4000, 0); stepCycle();
    applyStimulus(0, 0, 1, 2'd0, 5'd7, 4'd0, 32'h77, 1);
    checkOutput("stg_off_ready", 32'(in_ready), 32'd0);
    stepCycle();
    checkOutput("stg_off_rf_we", 32'(rf_we), 32'd0);
    applyStimulus(0, 1, 1, 2'd1, 5'd6, 4'd0, 32'h88, 0); stepCycle();
    checkOutput("vl0_vrf_we", 32'(vrf_we), 32'd0);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, 1, 1, 2'd1, 5'd6, 4'd12, 32'hC0 + 32'(i), 0);
      stepCycle();
      checkOutput("vlmax_elem", 32'(vrf_elem), 32'(i));
      checkOutput("vlmax_done", 32'(vec_done), 32'(i == 7));
    end

    // Randomized traffic; vl only changes between vector ops.
    for (int i = 0; i < 600; i++) begin
      if (m_elem == 0) cur_vl = 4'($urandom_range(0, 15));
      applyStimulus(($urandom_range(0, 63) == 0), ($urandom_range(0, 7) != 0),
                    1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                    5'($urandom_range(0, 31)), cur_vl, $urandom, 1'($urandom_range(0, 1)));
      stepCycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_router.md
WB_ROUTER -- requirements
Module: wb_router

Interface
- REQ-001: Parameters SHALL be, one per line:
  - XLEN, 32, datapath width.
  - VLMAX, 8, maximum vector elements per vector operation.
- REQ-002: Ports SHALL be, one per line:
  - clk  in  1  single clock; all state changes on its rising edge.
  - rst  in  1  reset, synchronous and active-high.
  - stg_en  in  1  stage enable; 0 SHALL block acceptance of new beats.
  - in_valid  in  1  ALU result beat valid.
  - in_ready  out  1  router can accept a beat.
  - res  in  XLEN  ALU result.
  - dest_sel  in  2  destination: 00 scalar RF, 01 vector RF, 10 LSU, 11 discard.
  - rd  in  5  destination register index (scalar or vector).
  - vl  in  4  active vector length in elements, valid range 0..VLMAX.
  - rf_we  out  1  scalar RF write enable.
  - rf_waddr  out  5  scalar RF write address.
  - rf_wdata  out  XLEN  scalar RF write data.
  - vrf_we  out  1  vector RF write enable.
  - vrf_waddr  out  5  vector register index.
  - vrf_elem  out  3  element index.
  - vrf_wdata  out  XLEN  vector element data.
  - vec_done  out  1  one-cycle pulse with the last element write of a vector op.
  - lsu_valid  out  1  LSU address/data beat valid.
  - lsu_ready  in  1  LSU accepts the beat.
  - lsu_data  out  XLEN  value presented to the LSU.

Function
- REQ-003: A beat SHALL be accepted in a cycle where in_valid && in_ready.
- REQ-004: in_ready SHALL be combinational, equal to stg_en && (!lsu_pending || lsu_ready).
- REQ-005: rf_we and vrf_we SHALL be registered one-cycle pulses in the cycle after acceptance. They SHALL be 0 in every other cycle, giving a latency of 1 cycle.
- REQ-006: A scalar beat SHALL register rf_waddr=rd and rf_wdata=res.
- REQ-007: A write to rd=0 SHALL be suppressed, with rf_we kept at 0.
- REQ-008: A vector beat SHALL register vrf_waddr=rd, vrf_elem=elem_cnt and vrf_wdata=res, then increment elem_cnt.
- REQ-009: When elem_cnt==vl-1 on a vector beat, elem_cnt SHALL wrap to 0 and vec_done SHALL pulse together with that vrf_we.
- REQ-010: A vector beat with vl=0 SHALL be consumed with no write, no vec_done and no counter change.
- REQ-011: A vector beat with vl>VLMAX SHALL be treated as vl=VLMAX.
- REQ-012: The state machine SHALL have three states: IDLE, VEC (elem_cnt!=0) and LSU_WAIT (lsu_pending=1). VEC and LSU_WAIT SHALL be tracked independently, so a vector op may be in progress while an LSU beat waits.
- REQ-013: Scalar, discard and LSU beats accepted while in VEC SHALL NOT modify elem_cnt.
- REQ-014: An LSU beat SHALL set lsu_pending=1 and register lsu_data=res in the next cycle, with lsu_valid=lsu_pending.
- REQ-015: lsu_data SHALL be held stable while lsu_valid && !lsu_ready.
- REQ-016: lsu_pending SHALL clear on lsu_valid && lsu_ready, unless a new LSU beat is accepted in the same cycle. In that case lsu_pending SHALL stay 1 and lsu_data SHALL load the new res, giving back-to-back LSU beats at one per cycle.
- REQ-017: A discard beat SHALL be consumed with no output effect.
- REQ-018: When stg_en drops, in-flight write pulses from beats already accepted SHALL still complete. A pending LSU beat SHALL remain valid until accepted.
- REQ-019: A scalar write and an LSU handshake in the same cycle SHALL both complete independently.

Reset
- REQ-020: In a cycle with rst=1, the following SHALL all become 0 at the next edge: rf_we, vrf_we, vec_done, lsu_valid, lsu_pending, elem_cnt, rf_waddr, rf_wdata, vrf_waddr, vrf_elem, vrf_wdata and lsu_data.
- REQ-021: in_ready SHALL be 0 while rst=1.
- REQ-022: Reset SHALL take priority over any simultaneous handshake. A pending LSU beat or a partial vector op is abandoned, and after reset the next vector beat writes element 0.

Verification
- REQ-023: Scalar path: dest_sel=00, rd=5, res=0xDEADBEEF accepted at cycle N -> rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF at N+1; rf_we=0 at N+2.
- REQ-024: rd=0 scalar write: dest_sel=00, rd=0 accepted -> rf_we stays 0.
- REQ-025: Vector sweep: vl=3, rd=2, three vector beats with res=0x10, 0x11, 0x12 -> vrf_elem=0,1,2 in order, vec_done=1 only with elem 2. A fourth beat then writes elem 0.
- REQ-026: LSU backpressure: an LSU beat with res=0x1000 and lsu_ready=0 for 3 cycles -> lsu_valid=1 with lsu_data=0x1000 held and in_ready=0. When lsu_ready=1, in_ready=1 in the same cycle, and a new LSU beat with res=0x2000 loads with lsu_valid staying 1.
- REQ-027: Reset mid-operation: with vl=4, after two vector beats and an LSU beat pending, assert rst for 1 cycle -> all outputs 0. The next vector beat writes vrf_elem=0.
- REQ-028: Stage enable and vl=0: stg_en=0 with in_valid=1 -> in_ready=0 and no writes. A vector beat with vl=0 -> no vrf_we and elem_cnt stays unchanged.
